// File: rtl/pipe_datapath_if.sv
// pipe_datapath_if: instruction and data memory bus
// seen by the pipelined datapath.
interface pipe_datapath_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PCF;
  logic [31:0]     InstrF;
  logic            MemWriteM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] ReadDataM;

  modport master (
    output PCF,
    output MemWriteM,
    output ALUResultM,
    output WriteDataM,
    input  InstrF,
    input  ReadDataM
  );

  modport slave (
    input  PCF,
    input  MemWriteM,
    input  ALUResultM,
    input  WriteDataM,
    output InstrF,
    output ReadDataM
  );
endinterface

// File: rtl/pipe_datapath.sv
// pipe_datapath: five-stage RV32I datapath with M/W forwarding,
// load-use or interlock stalling and E-stage branch resolution.
module pipe_datapath #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FORWARDING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       JumpD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic [1:0] ResultSrcD,
  input  logic [1:0] ImmSrcD,
  input  logic [3:0] ALUControlD,
  output logic [6:0] OpD,
  output logic [2:0] Funct3D,
  output logic       Funct7b5D,
  pipe_datapath_if.master bus,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
);

  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc4;
  } ex_mem_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc4;
  } mem_wb_t;

  if_id_t  fd;
  id_ex_t  de;
  id_ex_t  de_n;
  ex_mem_t em;
  mem_wb_t mw;

  logic [XLEN-1:0] rf [32];

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_next;

  logic [31:0]     instr_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;

  logic            a_m, a_w, b_m, b_w;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] wd_e;
  logic [XLEN-1:0] alu_y;
  logic            zero_e;
  logic            pcsrc_e;
  logic [XLEN-1:0] pctarget_e;

  logic [XLEN-1:0] result_w;

  logic load_use, dep_e, dep_m, stall_req;

  // ---------------- fetch ----------------
  assign pc_plus4_f = pc_q + XLEN'(4);
  assign pc_next    = pcsrc_e ? pctarget_e : pc_plus4_f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pc_q <= RESET_PC;
    else if (!StallF) pc_q <= pc_next;
  end

  assign bus.PCF = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fd <= '0;
    end else if (FlushD) begin
      fd <= '0;
    end else if (!StallD) begin
      fd.instr <= bus.InstrF;
      fd.pc    <= pc_q;
      fd.pc4   <= pc_plus4_f;
    end
  end

  // ---------------- decode ----------------
  assign instr_d   = fd.instr;
  assign OpD       = instr_d[6:0];
  assign Funct3D   = instr_d[14:12];
  assign Funct7b5D = instr_d[30];
  assign rs1_d     = instr_d[19:15];
  assign rs2_d     = instr_d[24:20];
  assign rd_d      = instr_d[11:7];

  always_comb begin
    imm_d = '0;
    unique case (ImmSrcD)
      2'b00: imm_d = {{(XLEN-12){instr_d[31]}},
                      instr_d[31:20]};
      2'b01: imm_d = {{(XLEN-12){instr_d[31]}},
                      instr_d[31:25], instr_d[11:7]};
      2'b10: imm_d = {{(XLEN-12){instr_d[31]}},
                      instr_d[7], instr_d[30:25],
                      instr_d[11:8], 1'b0};
      2'b11: imm_d = {{(XLEN-20){instr_d[31]}},
                      instr_d[19:12], instr_d[20],
                      instr_d[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mw.reg_write && mw.rd != 5'd0)
      rf[mw.rd] <= result_w;
  end

  // W bypass lets a same-cycle writeback reach D
  always_comb begin
    rd1_d = rf[rs1_d];
    rd2_d = rf[rs2_d];
    if (mw.reg_write && mw.rd == rs1_d) rd1_d = result_w;
    if (mw.reg_write && mw.rd == rs2_d) rd2_d = result_w;
    if (rs1_d == 5'd0) rd1_d = '0;
    if (rs2_d == 5'd0) rd2_d = '0;
  end

  always_comb begin
    de_n            = '0;
    de_n.reg_write  = RegWriteD;
    de_n.mem_write  = MemWriteD;
    de_n.jump       = JumpD;
    de_n.branch     = BranchD;
    de_n.alu_src    = ALUSrcD;
    de_n.result_src = ResultSrcD;
    de_n.alu_ctl    = ALUControlD;
    de_n.rd1        = rd1_d;
    de_n.rd2        = rd2_d;
    de_n.rs1        = rs1_d;
    de_n.rs2        = rs2_d;
    de_n.rd         = rd_d;
    de_n.imm        = imm_d;
    de_n.pc         = fd.pc;
    de_n.pc4        = fd.pc4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      de <= '0;
    else if (FlushE) de <= '0;
    else             de <= de_n;
  end

  // ---------------- execute ----------------
  assign a_m = de.rs1 != 5'd0 && de.rs1 == em.rd
               && em.reg_write;
  assign a_w = de.rs1 != 5'd0 && de.rs1 == mw.rd
               && mw.reg_write;
  assign b_m = de.rs2 != 5'd0 && de.rs2 == em.rd
               && em.reg_write;
  assign b_w = de.rs2 != 5'd0 && de.rs2 == mw.rd
               && mw.reg_write;

  always_comb begin
    src_a = de.rd1;
    wd_e  = de.rd2;
    if (FORWARDING != 0) begin
      if (a_m)      src_a = em.alu_result;
      else if (a_w) src_a = result_w;
      if (b_m)      wd_e  = em.alu_result;
      else if (b_w) wd_e  = result_w;
    end
  end

  assign src_b = de.alu_src ? de.imm : wd_e;

  always_comb begin
    alu_y = '0;
    unique case (de.alu_ctl)
      ALU_ADD:  alu_y = src_a + src_b;
      ALU_SUB:  alu_y = src_a - src_b;
      ALU_AND:  alu_y = src_a & src_b;
      ALU_OR:   alu_y = src_a | src_b;
      ALU_XOR:  alu_y = src_a ^ src_b;
      ALU_SLT:  alu_y = XLEN'($signed(src_a)
                               < $signed(src_b));
      ALU_SLTU: alu_y = XLEN'(src_a < src_b);
      ALU_SLL:  alu_y = src_a << src_b[SW-1:0];
      ALU_SRL:  alu_y = src_a >> src_b[SW-1:0];
      ALU_SRA:  alu_y = $unsigned($signed(src_a)
                                  >>> src_b[SW-1:0]);
      default:  alu_y = '0;
    endcase
  end

  assign zero_e     = alu_y == '0;
  assign pctarget_e = de.pc + de.imm;
  assign pcsrc_e    = de.jump | (de.branch & zero_e);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      em <= '0;
    end else begin
      em.reg_write  <= de.reg_write;
      em.mem_write  <= de.mem_write;
      em.result_src <= de.result_src;
      em.alu_result <= alu_y;
      em.write_data <= wd_e;
      em.rd         <= de.rd;
      em.pc4        <= de.pc4;
    end
  end

  // ---------------- memory ----------------
  assign bus.MemWriteM  = em.mem_write;
  assign bus.ALUResultM = em.alu_result;
  assign bus.WriteDataM = em.write_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mw <= '0;
    end else begin
      mw.reg_write  <= em.reg_write;
      mw.result_src <= em.result_src;
      mw.alu_result <= em.alu_result;
      mw.read_data  <= bus.ReadDataM;
      mw.rd         <= em.rd;
      mw.pc4        <= em.pc4;
    end
  end

  // ---------------- writeback ----------------
  always_comb begin
    result_w = mw.alu_result;
    unique case (mw.result_src)
      2'b01:   result_w = mw.read_data;
      2'b10:   result_w = mw.pc4;
      default: result_w = mw.alu_result;
    endcase
  end

  // ---------------- hazards ----------------
  assign load_use = de.result_src == 2'b01
                    && de.rd != 5'd0
                    && (de.rd == rs1_d || de.rd == rs2_d);

  assign dep_e = de.reg_write && de.rd != 5'd0
                 && (de.rd == rs1_d || de.rd == rs2_d);

  assign dep_m = em.reg_write && em.rd != 5'd0
                 && (em.rd == rs1_d || em.rd == rs2_d);

  assign stall_req = (FORWARDING != 0) ? load_use
                                       : (dep_e | dep_m);

  // a taken branch wins: the stalled instruction is flushed
  assign StallF = stall_req & ~pcsrc_e;
  assign StallD = stall_req & ~pcsrc_e;
  assign FlushD = pcsrc_e;
  assign FlushE = stall_req | pcsrc_e;

endmodule

// File: doc/pipe_datapath.md
# pipe_datapath

Five-stage (F/D/E/M/W) pipelined RV32I datapath that succeeds the single-cycle datapath in this processor. It is parametrised in data width, reset vector and hazard mode. It pairs with the existing decode-stage controller, the instruction memory and the data memory. It adds pipeline registers, operand forwarding, load-use stalling and branch/jump flushing, so the core sustains one instruction per cycle without a hazard-free program.

## Interface
- XLEN, 32, datapath and register width; immediates sign-extend to XLEN.
- RESET_PC, 0, PCF value while reset is asserted.
- FORWARDING, 1, selects hazard mode: 1 = M/W→E forwarding; 0 = stall-only interlock.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode-stage controls from the controller.
- ResultSrcD  in  2  result select: 00 ALU, 01 load data, 10 PC+4.
- ImmSrcD  in  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- ALUControlD  in  4  ALU operation, same encoding as the existing alu.
- OpD  out  7  InstrD[6:0], fed to the controller.
- Funct3D  out  3  InstrD[14:12], fed to the controller.
- Funct7b5D  out  1  InstrD[30], fed to the controller.
- PCF  out  XLEN  fetch address to instruction memory.
- InstrF  in  32  instruction from instruction memory; combinational read.
- MemWriteM  out  1  data-memory write enable.
- ALUResultM  out  XLEN  data-memory address.
- WriteDataM  out  XLEN  data-memory store data.
- ReadDataM  in  XLEN  data-memory load data; combinational read.
- StallF, StallD, FlushD, FlushE  out  1 each  hazard status; observable for verification.

## Operation
- Pipeline registers:
  - F→D holds InstrD, PCD, PCPlus4D.
  - D→E holds controls, RD1, RD2, rs1, rs2, rd, ImmExt, PC, PC+4.
  - E→M holds controls, ALUResult, WriteData, rd, PC+4.
  - M→W holds RegWrite, ResultSrc, ALUResult, ReadData, rd, PC+4.
- Register file:
  - Written on the rising edge by W.
  - Reads of x0 return 0.
  - A D-stage read of a register that W writes in the same cycle returns the new value (internal bypass).
- Branch/jump:
  - Resolved in E: PCSrcE = JumpE | (BranchE & ZeroE).
  - PCTargetE = PCE + ImmExtE.
  - On PCSrcE: PCF ← PCTargetE next edge; FlushD and FlushE both assert, turning the two younger instructions into bubbles.
- Forwarding (FORWARDING=1), applied per E source operand:
  - If rsE ≠ 0, rsE = rdM and RegWriteM: take ALUResultM.
  - Else if rsE ≠ 0, rsE = rdW and RegWriteW: take ResultW.
  - Else: take the register value.
  - M has priority over W.
  - The forwarded rs2 value also feeds WriteDataE.
- Load-use (FORWARDING=1):
  - Condition: ResultSrcE = 01 and rdE ∈ {rs1D, rs2D}, rdE ≠ 0.
  - Action: StallF = StallD = 1 and FlushE = 1; exactly one bubble.
- Interlock (FORWARDING=0):
  - Stall D while any nonzero rsD matches rdE or rdM of an instruction with RegWrite = 1.
  - A producer in E costs 2 bubbles; a producer in M costs 1.
- Simultaneous events:
  - A taken branch in E overrides a stall request from D.
  - The stalled younger instruction is flushed; PC takes the target.
- Bubble: all controls zero, so RegWrite, MemWrite, Jump and Branch are 0. Datapath fields are don't-care but are also zeroed.

## Timing
- Reset asserted:
  - PCF = RESET_PC.
  - All pipeline registers cleared to bubbles.
  - MemWriteM = 0.
  - Stall/flush outputs reflect bubbles (all 0).
  - The register file is not reset.
- First edge after reset deasserts: the instruction at RESET_PC moves to D; PCF becomes RESET_PC+4.
- Latency: an instruction fetched in cycle n writes back at the edge ending cycle n+4.
- Throughput: 1 instruction per cycle with no hazards.
- Hazard cost:
  - Taken branch/jump: 2 cycles.
  - Load-use: 1 cycle.
- ALU arithmetic wraps modulo 2^XLEN. The PC adders also wrap.
- Reset asserted mid-operation: in-flight instructions are discarded. A store in M does not write, because MemWriteM drops asynchronously.

## Test plan
- Reset: hold reset low 3 cycles, RESET_PC=0x100 → PCF=0x100, MemWriteM=0; after release PCF steps 0x104, 0x108.
- Forwarding: `addi x1,x0,5`; `add x2,x1,x1`; `add x3,x2,x1` → x2=10, x3=15, no stalls.
- Load-use: mem[0]=7; `lw x4,0(x0)`; `add x5,x4,x4` → x5=14, exactly one StallD cycle.
- Branch: `beq x0,x0,+12` followed by two `addi` → FlushD and FlushE pulse for one cycle, the skipped addis never write, PC lands at target.
- Store: `sw x2,8(x0)` straight after the producer of x2 → MemWriteM=1, ALUResultM=8, WriteDataM=forwarded value.
- FORWARDING=0: rerun the forwarding program → results identical, 2 stall cycles per back-to-back dependency.
